div32: RTL and testbench
========================

# div32

Iterative 32-bit integer divider for the RV32M execution stage, the inverse companion of the pipelined Booth multiplier. It accepts one operand pair through a valid/ready handshake, produces quotient and remainder with RISC-V DIV/DIVU/REM/REMU semantics, and holds the result until the next operation completes. It uses one restoring quotient bit per cycle, with a fixed latency for normal operations and a single-cycle fast path for the architectural special cases.

## Interface
- DATA_WIDH, 32, operand and result width; latency scales with it.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- valid_input  input  1  operand pair present; sampled only when ready=1.
- is_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
- a  input  DATA_WIDH  dividend.
- b  input  DATA_WIDH  divisor.
- ready  output  1  block is in IDLE and will accept valid_input this cycle.
- valid_output  output  1  one-cycle pulse: R_quot/R_rem are newly valid.
- R_quot  output  DATA_WIDH  quotient, held until the next result.
- R_rem  output  DATA_WIDH  remainder, held until the next result.

## Operation
- States: IDLE, CALC, FIX, DONE. ready=1 only in IDLE.
- IDLE, valid_input=1 (accept edge T): register a, b, is_signed; record sign_a=is_signed&a[31], sign_b=is_signed&b[31], neg_q=sign_a^sign_b, neg_r=sign_a; load magnitudes |a|, |b| (0x80000000 stays 0x80000000 as an unsigned magnitude).
  - b==0: R_quot=all ones, R_rem=a; go to DONE.
  - is_signed & a==0x80000000 & b==0xFFFFFFFF: R_quot=0x80000000, R_rem=0; go to DONE.
  - otherwise: partial remainder=0, quotient register=|a|, counter=0; go to CALC.
- CALC, one step per edge: trial={rem[30:0], q[31]} − |b| in 33 bits. If non-negative, rem=trial and shift in 1; else rem={rem[30:0], q[31]} and shift in 0. After 32 steps (counter reaches DATA_WIDH−1), go to FIX.
- FIX: R_quot = neg_q ? −q : q; R_rem = neg_r ? −rem : rem (two's complement, mod 2^32). Go to DONE.
- DONE: valid_output=1 for this cycle only; go to IDLE.
- valid_input outside IDLE is ignored: not queued, no error.
- a, b, is_signed changing after acceptance have no effect.
- Remainder sign follows the dividend; quotient truncates toward zero.

## Timing
- Reset (async, any state, including mid-CALC): state=IDLE, counter=0, all internal registers=0, R_quot=0, R_rem=0, valid_output=0, ready=1. The in-flight operation is discarded with no output pulse.
- Normal path, accepted at edge T: CALC steps at edges T+1..T+32, FIX at T+33 (outputs updated, valid_output rises), DONE→IDLE at T+34 (valid_output falls). Latency is DATA_WIDH+1 edges.
- Special cases, accepted at edge T: outputs updated and valid_output high from T+1, falls at T+2.
- ready falls on the edge after acceptance and rises on the edge leaving DONE. Back-to-back throughput is one operation per 35 cycles normal and per 3 cycles special.
- R_quot/R_rem change only on the edge that asserts valid_output; they are stable otherwise.

## Test plan
- Unsigned 100 / 7, accepted at T -> valid_output pulse set by edge T+33, R_quot=14, R_rem=2; ready=0 during T+1..T+34.
- Signed 0xFFFFFFF9 (−7) / 2 -> R_quot=0xFFFFFFFD, R_rem=0xFFFFFFFF; 7 / 0xFFFFFFFE -> R_quot=0xFFFFFFFD, R_rem=1.
- Divide by zero, a=5, b=0, both modes -> at T+1, R_quot=0xFFFFFFFF, R_rem=5; valid_output high one cycle.
- Overflow a=0x80000000, b=0xFFFFFFFF: signed -> at T+1, R_quot=0x80000000, R_rem=0. Unsigned -> full latency, R_quot=0, R_rem=0x80000000.
- Busy/ignore: accept 1000/3. Assert valid_input with 9/9 at T+5 and change a/b at T+6 -> single result R_quot=333, R_rem=1. Next accept at the first IDLE cycle gives 9/9 -> R_quot=1, R_rem=0.
- Reset mid-CALC at T+10 -> outputs 0, ready=1 immediately, no valid_output pulse. A subsequent 0xFFFFFFFF/0x10 unsigned -> R_quot=0x0FFFFFFF, R_rem=0xF.

Source files
------------

// File: rtl/div32.sv
// -----------------------------------------------------------------------------
// div32 -- iterative integer divider for the RV32M execution stage.
//
// Accepts one operand pair via a valid/ready handshake and returns quotient
// and remainder with RISC-V DIV/DIVU/REM/REMU semantics. Normal operations
// run a restoring divider at one quotient bit per clock and use DATA_WIDH+1
// clock edges from acceptance to result. Divide-by-zero and signed overflow
// bypass the iteration loop and produce their result one edge after
// acceptance.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   valid_input   operand pair present (sampled only while ready=1)
//   is_signed     1 = DIV/REM, 0 = DIVU/REMU
//   a             dividend
//   b             divisor
//   ready         block is idle and accepts valid_input this cycle
//   valid_output  one-cycle pulse: R_quot/R_rem were just updated
//   R_quot        quotient, held until the next result
//   R_rem         remainder, held until the next result
// -----------------------------------------------------------------------------
module div32 #(
  parameter int DATA_WIDH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_input,
  input  logic                 is_signed,
  input  logic [DATA_WIDH-1:0] a,
  input  logic [DATA_WIDH-1:0] b,
  output logic                 ready,
  output logic                 valid_output,
  output logic [DATA_WIDH-1:0] R_quot,
  output logic [DATA_WIDH-1:0] R_rem
);

  localparam int W  = DATA_WIDH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [W-1:0]   rem_reg, rem_next;    // partial remainder
  logic [W-1:0]   quo_reg, quo_next;    // dividend shifts out, quotient shifts in
  logic [W-1:0]   div_reg, div_next;    // divisor magnitude
  logic           neg_q_reg, neg_q_next;
  logic           neg_r_reg, neg_r_next;
  logic [W-1:0]   res_q_reg, res_q_next;
  logic [W-1:0]   res_r_reg, res_r_next;

  // Operand decode at acceptance time.
  logic           sign_a, sign_b;
  logic [W-1:0]   a_mag, b_mag;

  // One restoring step: shift the next dividend bit into the remainder and
  // try to subtract the divisor. The 33-bit difference exposes the borrow.
  // Dropping rem_reg[W-1] during the shift is safe: the remainder only reaches
  // the top bit on the final step, or never when the divisor fits in W-1 bits.
  logic [W-1:0]   shifted;
  logic [W:0]     trial;

  assign sign_a = is_signed & a[W-1];
  assign sign_b = is_signed & b[W-1];
  // Negating the most negative value yields itself, which is the correct
  // unsigned magnitude.
  assign a_mag  = sign_a ? (~a + 1'b1) : a;
  assign b_mag  = sign_b ? (~b + 1'b1) : b;

  assign shifted = {rem_reg[W-2:0], quo_reg[W-1]};
  assign trial   = {1'b0, shifted} - {1'b0, div_reg};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      div_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      res_q_reg <= '0;
      res_r_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      div_reg   <= div_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      res_q_reg <= res_q_next;
      res_r_reg <= res_r_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rem_next   = rem_reg;
    quo_next   = quo_reg;
    div_next   = div_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    res_q_next = res_q_reg;
    res_r_next = res_r_reg;

    unique case (state_reg)
      IDLE: begin
        if (valid_input) begin
          cnt_next = '0;
          div_next = b_mag;
          if (b == '0) begin
            // Special cases park the final answer in quo/rem with both sign
            // flags cleared, so FIX copies it to the outputs unchanged. This
            // keeps the output update and the valid pulse on one path.
            quo_next   = ALL_ONES;
            rem_next   = a;
            neg_q_next = 1'b0;
            neg_r_next = 1'b0;
            state_next = FIX;
          end else if (is_signed && (a == MIN_NEG) && (b == ALL_ONES)) begin
            quo_next   = MIN_NEG;
            rem_next   = '0;
            neg_q_next = 1'b0;
            neg_r_next = 1'b0;
            state_next = FIX;
          end else begin
            quo_next   = a_mag;
            rem_next   = '0;
            neg_q_next = sign_a ^ sign_b;
            neg_r_next = sign_a;
            state_next = CALC;
          end
        end
      end

      CALC: begin
        if (!trial[W]) begin
          rem_next = trial[W-1:0];
          quo_next = {quo_reg[W-2:0], 1'b1};
        end else begin
          rem_next = shifted;
          quo_next = {quo_reg[W-2:0], 1'b0};
        end
        // Counter wraps back to zero after the last step.
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next = FIX;
        end
      end

      FIX: begin
        res_q_next = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
        res_r_next = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
        state_next = DONE;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ready        = (state_reg == IDLE);
  assign valid_output = (state_reg == DONE);
  assign R_quot       = res_q_reg;
  assign R_rem        = res_r_reg;

endmodule

// File: tb/tb_div32.sv
// -----------------------------------------------------------------------------
// tb_div32 -- self-checking bench for div32.
// Expected results come from a behavioural model and travel through a
// scoreboard queue from the moment an operation is accepted until the DUT
// pulses valid_output.
// -----------------------------------------------------------------------------
module tb_div32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_input = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready;
  logic        valid_output;
  logic [31:0] R_quot;
  logic [31:0] R_rem;

  div32 #(.DATA_WIDH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_input  (valid_input),
    .is_signed    (is_signed),
    .a            (a),
    .b            (b),
    .ready        (ready),
    .valid_output (valid_output),
    .R_quot       (R_quot),
    .R_rem        (R_rem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   accept_cyc = 0;

  // Behavioural reference: RISC-V division semantics.
  function automatic exp_t div_model(input logic [31:0] av, input logic [31:0] bv,
                                     input logic sg);
    exp_t e;
    if (bv == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = av; e.lat = 1;
    end else if (sg && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.lat = 1;
    end else if (sg) begin
      e.q = $signed(av) / $signed(bv);
      e.r = $signed(av) % $signed(bv);
      e.lat = 33;
    end else begin
      e.q = av / bv; e.r = av % bv; e.lat = 33;
    end
    return e;
  endfunction

  // Drive one operation at the first ready cycle; returns at the negedge
  // after the accepting edge.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sg);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!ready) begin
      n_checks++;
      $display("FAIL start_timeout ready=%0b required 1", ready);
      $fatal(1, "ready never returned");
    end
    a = av; b = bv; is_signed = sg; valid_input = 1'b1;
    @(posedge clk);
    #1 accept_cyc = cyc;
    sb.push_back(div_model(av, bv, sg));
    @(negedge clk);
    valid_input = 1'b0;
  endtask

  // Wait (bounded) for the result pulse; reports latency in edges since
  // acceptance, or -1 on timeout. Also checks outputs hold until the pulse.
  task automatic wait_result(output logic [31:0] gq, output logic [31:0] gr,
                             output int lat);
    logic [31:0] q0, r0;
    bit          stable;
    int          n;
    q0 = R_quot; r0 = R_rem; stable = 1'b1; n = 0; lat = -1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (valid_output) break;
      if (R_quot !== q0 || R_rem !== r0) stable = 1'b0;
    end
    if (valid_output) lat = cyc - accept_cyc;
    gq = R_quot; gr = R_rem;
    n_checks++;
    if (!stable) $display("FAIL hold outputs changed before pulse (q=%h r=%h, held q=%h r=%h)",
                          R_quot, R_rem, q0, r0);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b need 1", ready); else n_pass++;
    n_checks++; if (valid_output !== 1'b0) $display("FAIL reset_valid got %b need 0", valid_output); else n_pass++;
    n_checks++; if (R_quot !== 32'd0) $display("FAIL reset_quot got %h need 0", R_quot); else n_pass++;
    n_checks++; if (R_rem !== 32'd0) $display("FAIL reset_rem got %h need 0", R_rem); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [31:0] gq, gr;
    int lat;
    exp_t e;
    start_op(32'd100, 32'd7, 1'b0);
    n_checks++; if (ready !== 1'b0) $display("FAIL udiv_busy ready got %b need 0", ready); else n_pass++;
    wait_result(gq, gr, lat);
    e = sb.pop_front();
    n_checks++; if (gq !== e.q) $display("FAIL udiv_quot got %h need %h", gq, e.q); else n_pass++;
    n_checks++; if (gr !== e.r) $display("FAIL udiv_rem got %h need %h", gr, e.r); else n_pass++;
    n_checks++; if (lat !== e.lat) $display("FAIL udiv_latency got %0d need %0d", lat, e.lat); else n_pass++;
    n_checks++; if (ready !== 1'b0) $display("FAIL udiv_ready_done got %b need 0", ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (valid_output !== 1'b0) $display("FAIL udiv_pulse_width got %b need 0", valid_output); else n_pass++;
    n_checks++; if (ready !== 1'b1) $display("FAIL udiv_ready_back got %b need 1", ready); else n_pass++;
    $display("udiv 100/7 -> q=%0d r=%0d lat=%0d", gq, gr, lat);
  endtask

  // Signed, divide-by-zero and overflow vectors share one table.
  task automatic test_special();
    logic [31:0] ta [6] = '{32'hFFFF_FFF9, 32'd7,         32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb [6] = '{32'd2,         32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic        ts [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] gq, gr;
    int lat;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      start_op(ta[i], tb[i], ts[i]);
      wait_result(gq, gr, lat);
      e = sb.pop_front();
      n_checks++; if (gq !== e.q) $display("FAIL vec%0d_quot got %h need %h", i, gq, e.q); else n_pass++;
      n_checks++; if (gr !== e.r) $display("FAIL vec%0d_rem got %h need %h", i, gr, e.r); else n_pass++;
      n_checks++; if (lat !== e.lat) $display("FAIL vec%0d_latency got %0d need %0d", i, lat, e.lat); else n_pass++;
      @(negedge clk);
      n_checks++; if (valid_output !== 1'b0) $display("FAIL vec%0d_pulse_width got %b need 0", i, valid_output); else n_pass++;
      $display("vec%0d %h/%h s=%0b -> q=%h r=%h lat=%0d", i, ta[i], tb[i], ts[i], gq, gr, lat);
    end
  endtask

  task automatic test_busy();
    logic [31:0] gq, gr;
    int lat;
    exp_t e;
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (4) @(negedge clk);
    valid_input = 1'b1; a = 32'd9; b = 32'd9;           // sampled at T+5, ignored
    @(negedge clk);
    a = 32'd123; b = 32'd45;                            // T+6 change, ignored
    @(negedge clk);
    a = 32'd9; b = 32'd9;
    wait_result(gq, gr, lat);
    e = sb.pop_front();
    n_checks++; if (gq !== e.q) $display("FAIL busy_quot got %0d need %0d", gq, e.q); else n_pass++;
    n_checks++; if (gr !== e.r) $display("FAIL busy_rem got %0d need %0d", gr, e.r); else n_pass++;
    n_checks++; if (lat !== e.lat) $display("FAIL busy_latency got %0d need %0d", lat, e.lat); else n_pass++;
    $display("busy 1000/3 -> q=%0d r=%0d lat=%0d", gq, gr, lat);
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) $display("FAIL busy_ready_back got %b need 1", ready); else n_pass++;
    @(posedge clk);
    #1 accept_cyc = cyc;
    sb.push_back(div_model(32'd9, 32'd9, 1'b0));
    @(negedge clk);
    valid_input = 1'b0;
    n_checks++; if (ready !== 1'b0) $display("FAIL busy_second_accept ready got %b need 0", ready); else n_pass++;
    wait_result(gq, gr, lat);
    e = sb.pop_front();
    n_checks++; if (gq !== e.q) $display("FAIL busy2_quot got %0d need %0d", gq, e.q); else n_pass++;
    n_checks++; if (gr !== e.r) $display("FAIL busy2_rem got %0d need %0d", gr, e.r); else n_pass++;
    n_checks++; if (lat !== e.lat) $display("FAIL busy2_latency got %0d need %0d", lat, e.lat); else n_pass++;
    $display("busy 9/9 -> q=%0d r=%0d lat=%0d", gq, gr, lat);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] gq, gr;
    int lat;
    int pulses;
    exp_t e;
    start_op(32'd123456, 32'd11, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    n_checks++; if (ready !== 1'b1) $display("FAIL rstmid_ready got %b need 1", ready); else n_pass++;
    n_checks++; if (R_quot !== 32'd0) $display("FAIL rstmid_quot got %h need 0", R_quot); else n_pass++;
    n_checks++; if (R_rem !== 32'd0) $display("FAIL rstmid_rem got %h need 0", R_rem); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_output) pulses++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL rstmid_no_pulse got %0d pulses need 0", pulses); else n_pass++;
    $display("reset mid-CALC -> pulses=%0d", pulses);
    start_op(32'hFFFF_FFFF, 32'h10, 1'b0);
    wait_result(gq, gr, lat);
    e = sb.pop_front();
    n_checks++; if (gq !== e.q) $display("FAIL postrst_quot got %h need %h", gq, e.q); else n_pass++;
    n_checks++; if (gr !== e.r) $display("FAIL postrst_rem got %h need %h", gr, e.r); else n_pass++;
    n_checks++; if (lat !== e.lat) $display("FAIL postrst_latency got %0d need %0d", lat, e.lat); else n_pass++;
    $display("post-reset ffffffff/10 -> q=%h r=%h lat=%0d", gq, gr, lat);
  endtask

  // Random operations issued as soon as ready returns; also checks the
  // spacing between acceptances (35 cycles normal, 3 special).
  task automatic test_back_to_back();
    logic [31:0] gq, gr, av, bv;
    logic        sg;
    int lat, prev_acc, prev_lat;
    exp_t e;
    prev_acc = 0; prev_lat = 0;
    for (int i = 0; i < 10; i++) begin
      av = $urandom;
      bv = (i % 4 == 1) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      if (bv == 32'd0 && i % 4 != 1) bv = 32'd3;
      sg = 1'(i & 1);
      start_op(av, bv, sg);
      if (i > 0) begin
        n_checks++;
        if (accept_cyc - prev_acc !== prev_lat + 2)
          $display("FAIL b2b%0d_spacing got %0d need %0d", i, accept_cyc - prev_acc, prev_lat + 2);
        else n_pass++;
      end
      wait_result(gq, gr, lat);
      e = sb.pop_front();
      n_checks++; if (gq !== e.q) $display("FAIL b2b%0d_quot got %h need %h", i, gq, e.q); else n_pass++;
      n_checks++; if (gr !== e.r) $display("FAIL b2b%0d_rem got %h need %h", i, gr, e.r); else n_pass++;
      n_checks++; if (lat !== e.lat) $display("FAIL b2b%0d_latency got %0d need %0d", i, lat, e.lat); else n_pass++;
      $display("b2b%0d %h/%h s=%0b -> q=%h r=%h lat=%0d", i, av, bv, sg, gq, gr, lat);
      prev_acc = accept_cyc;
      prev_lat = e.lat;
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_unsigned();
    test_special();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
